// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants for the instruction fetch unit. This covers
//                the datapath width, the fetch FSM state encodings and a helper
//                that places a word index into a full-width address.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int XLEN = 32;

  // Fetch FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;  // halted; loader port is serviced here
  localparam logic [1:0] S_REQ  = 2'd1;  // read strobe on the memory bus
  localparam logic [1:0] S_RSP  = 2'd2;  // memory read data arrives this cycle
  localparam logic [1:0] S_HOLD = 2'd3;  // instruction presented to decode

  // Place a 4-bit word index into a full-width address. The upper bits are
  // zero. The top-level uses its own width for general DEPTH values.
  function automatic logic [XLEN-1:0] zext4(input logic [3:0] a);
    return {{(XLEN-4){1'b0}}, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Initiator side of a single-port instruction/data memory.
//                It issues word reads at the current pc and captures the read
//                data, which has a 1-cycle latency. It presents instructions
//                to decode over a valid/ready handshake. It supports branch
//                redirect and run/halt control. A loader port writes program
//                words into memory while the unit is halted.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                run                           - fetch enable
//                redirect_valid/redirect_pc    - branch target injection
//                inst_valid/inst_ready/
//                inst_data/inst_pc             - decode handshake
//                load_valid/load_addr/
//                load_data/load_ready          - program loader
//                PC/rd/wr/i_data/o_data        - memory interface
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic [XLEN-1:0] PC,
  output logic            rd,
  output logic            wr,
  output logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic [AW-1:0]   inst_pc_q, inst_pc_d;

  logic            handshake;
  logic            load_accept;

  // Only the low AW address bits are meaningful. The upper bits are ignored.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{redirect_pc[XLEN-1:AW], load_addr[XLEN-1:AW]};

  assign handshake   = (state_q == S_HOLD) && inst_valid_q && inst_ready;
  // The loader is only serviced when the unit is idle and stays idle.
  assign load_accept = !rst && (state_q == S_IDLE) && !run && load_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_RSP;
      end
      S_RSP: begin
        inst_data_d  = o_data;
        inst_pc_d    = pc_q;
        inst_valid_d = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (handshake) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + AW'(1);  // power-of-two DEPTH wraps naturally
          state_d      = run ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides the sequential pc. It kills any presented
    // instruction and discards a read that is still in flight. A handshake in
    // the same cycle still completes, because inst_valid simply drops.
    if (redirect_valid) begin
      pc_d         = redirect_pc[AW-1:0];
      inst_valid_d = 1'b0;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      state_d      = run ? S_REQ : S_IDLE;
    end

    // Memory strobes are registered. They are computed from the state being
    // entered, so rd is high exactly while the FSM sits in S_REQ.
    rd_d    = (state_d == S_REQ);
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (rd_d) begin
      addr_d = pc_d;
    end else if (load_accept) begin
      wr_d    = 1'b1;
      addr_d  = load_addr[AW-1:0];
      wdata_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= AW'(RESET_PC);
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign PC         = {{(XLEN-AW){1'b0}}, addr_q};
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign i_data     = wdata_q;
  assign load_ready = load_accept;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = {{(XLEN-AW){1'b0}}, inst_pc_q};

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit paired with a 16-word
//                synchronous memory. It applies directed load and fetch
//                sequences and then randomized run/ready/redirect traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, redirect_valid, inst_ready, load_valid;
  logic [31:0] redirect_pc, load_addr, load_data, o_data;
  logic        inst_valid, load_ready, rd, wr;
  logic [31:0] inst_data, inst_pc, PC, i_data;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready),
    .PC(PC), .rd(rd), .wr(wr), .i_data(i_data), .o_data(o_data)
  );

  // Memory attached to the DUT: synchronous write, registered read
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wr) mem[PC[3:0]] <= i_data;
    if (rd) o_data <= mem[PC[3:0]];
  end

  // Bench-side image of what the memory should hold
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_pc;
  } load_vec_t;
  load_vec_t lv [9];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a read strobe at word k, then expect word k two cycles later
  task automatic fetch_expect(input int k);
    int c;
    c = 0;
    while (!rd && c < 12) begin
      tick();
      c++;
    end
    chk("rd_seen", rd, 1);
    chk("req_pc", PC, k);
    tick();
    chk("rsp_not_valid", inst_valid, 0);
    tick();
    chk("valid_lat2", inst_valid, 1);
    chk("inst_pc", inst_pc, k);
    chk("inst_data", inst_data, ref_mem[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prog [9];
    int          exp_pc;
    int          hs;
    bit          pend_stall;
    logic [31:0] st_pc, st_data;

    prog = '{32'h66618213, 32'h00108093, 32'h00208113, 32'h003081b3, 32'h40208233,
             32'h0041a2b3, 32'h00c0006f, 32'h0061d213, 32'h4061d213};
    // Some loader addresses carry junk in the upper bits, which must be ignored
    for (int i = 0; i < 9; i++) begin
      lv[i].addr   = 32'(i) | ((i % 3 == 1) ? 32'hA5A5_0030 : 32'h0);
      lv[i].data   = prog[i];
      lv[i].exp_pc = 32'(i);
    end

    rst = 1; run = 0; redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    load_valid = 0; load_addr = 0; load_data = 0;
    tick(); tick();

    // Reset state
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_i_data", i_data, 0);
    chk("rst_load_ready", load_ready, 0);
    rst = 0;

    // Loader, table-driven, one write per cycle
    for (int i = 0; i < 9; i++) begin
      load_valid = 1; load_addr = lv[i].addr; load_data = lv[i].data;
      #1;
      chk("load_ready", load_ready, 1);
      tick();
      chk("load_wr", wr, 1);
      chk("load_PC", PC, lv[i].exp_pc);
      chk("load_i_data", i_data, lv[i].data);
      chk("load_no_rd", rd, 0);
      ref_mem[lv[i].exp_pc] = lv[i].data;
    end
    for (int i = 9; i < DEPTH; i++) begin
      load_addr = 32'(i); load_data = $urandom;
      ref_mem[i] = load_data;
      tick();
    end
    load_valid = 0;
    tick();
    chk("load_done_wr", wr, 0);
    chk("load_done_ready", load_ready, 0);

    // Sequential fetch
    run = 1; inst_ready = 1;
    fetch_expect(0); tick();
    fetch_expect(1); tick();

    // Redirect during S_RSP of pc=2: word 2 is never presented
    chk("rd_pc2", rd, 1);
    chk("req_pc2", PC, 2);
    tick();
    redirect_valid = 1; redirect_pc = 32'h0000_0107;
    tick();
    redirect_valid = 0;
    chk("redir_kill_valid", inst_valid, 0);
    chk("redir_rd", rd, 1);
    chk("redir_PC", PC, 7);
    fetch_expect(7);
    chk("redir_word7", inst_data, 32'h0061d213);
    tick();

    // Decode stalls 5 cycles in S_HOLD
    inst_ready = 0;
    fetch_expect(8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", inst_valid, 1);
      chk("stall_pc", inst_pc, 8);
      chk("stall_data", inst_data, ref_mem[8]);
      chk("stall_no_rd", rd, 0);
    end
    inst_ready = 1;
    tick();
    chk("after_stall_rd", rd, 1);
    chk("after_stall_PC", PC, 9);

    // Wrap from 15 to 0
    redirect_valid = 1; redirect_pc = 14;
    tick();
    redirect_valid = 0;
    fetch_expect(14); tick();
    fetch_expect(15); tick();
    fetch_expect(0);  tick();
    fetch_expect(1);

    // Reset while holding an instruction (pc=1)
    rst = 1; inst_ready = 0;
    tick();
    chk("hrst_valid", inst_valid, 0);
    chk("hrst_inst_pc", inst_pc, 0);
    chk("hrst_inst_data", inst_data, 0);
    chk("hrst_i_data", i_data, 0);
    chk("hrst_rd", rd, 0);
    chk("hrst_wr", wr, 0);
    rst = 0; inst_ready = 1;
    tick();
    chk("hrst_restart_rd", rd, 1);
    chk("hrst_restart_PC", PC, 0);

    // Halt mid-fetch: the current word completes, then no more reads
    run = 0;
    fetch_expect(0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("halt_no_rd", rd, 0);
      chk("halt_no_valid", inst_valid, 0);
      tick();
    end

    // Redirect and load together while idle
    redirect_valid = 1; redirect_pc = 5;
    load_valid = 1; load_addr = 3; load_data = 32'hdeadbeef;
    #1;
    chk("idle_redir_load_ready", load_ready, 1);
    tick();
    redirect_valid = 0; load_valid = 0;
    chk("idle_redir_wr", wr, 1);
    chk("idle_redir_PC", PC, 3);
    chk("idle_redir_i_data", i_data, 32'hdeadbeef);
    ref_mem[3] = 32'hdeadbeef;
    run = 1; inst_ready = 1;
    tick();
    fetch_expect(5); tick();
    redirect_valid = 1; redirect_pc = 3;
    tick();
    redirect_valid = 0;
    fetch_expect(3);
    tick();

    // Randomized traffic against a transaction-level model. The model only
    // tracks which word should be delivered next.
    exp_pc = 4; hs = 0; pend_stall = 0; st_pc = 0; st_data = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (pend_stall) begin
        chk("rnd_stall_valid", inst_valid, 1);
        chk("rnd_stall_pc", inst_pc, st_pc);
        chk("rnd_stall_data", inst_data, st_data);
      end
      chk("rnd_rd_wr_excl", rd & wr, 0);
      run            = ($urandom_range(15) != 0);
      inst_ready     = 1'($urandom_range(1));
      redirect_valid = (cyc == 0) || ($urandom_range(7) == 0);
      redirect_pc    = $urandom;
      if (inst_valid && inst_ready) begin
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst_data", inst_data, ref_mem[exp_pc]);
        exp_pc = (exp_pc + 1) % DEPTH;
        hs++;
      end
      if (redirect_valid) exp_pc = int'(redirect_pc % DEPTH);
      pend_stall = inst_valid && !inst_ready && !redirect_valid;
      st_pc      = inst_pc;
      st_data    = inst_data;
      tick();
    end
    chk("rnd_progress", hs > 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
